uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 143 ++++++++++++++
 tb/tb_uart_rx_cfg.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample majority vote per bit,
// optional parity, 1 or 2 stop bits, with frame-error and break reporting.
module uart_rx_cfg #(
  parameter int    CLOCK     = 50_000_000,
  parameter int    BAUD      = 115200,
  parameter int    DATA_BITS = 8,
  parameter string PARITY    = "None",
  parameter int    STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_vld,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int BIT_CNT = CLOCK / BAUD;
  localparam int MID     = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);

  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_VOTE = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  localparam bit HAS_PAR = (PARITY != "None");
  localparam bit ODD_PAR = (PARITY == "Odd");

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state, state_d;
  logic [1:0]           sync_q;
  logic [1:0]           sync_vld;
  logic                 rx_prev;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] data_sh;
  logic                 par_bit_q;
  logic                 stop_err_q;

  logic rx_s, fall, at_vote, bit_end, vote, decide, stop_bad;

  assign rx_s    = sync_q[1];
  assign fall    = rx_prev & ~rx_s;
  assign at_vote = (baud_cnt == CNT_VOTE);
  assign bit_end = (baud_cnt == CNT_LAST);
  assign vote    = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign stop_bad = stop_err_q | ~vote;
  assign busy    = (state != S_IDLE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state;
    decide  = 1'b0;
    case (state)
      S_IDLE:      if (fall) state_d = S_START;
      S_START: begin
        if (at_vote && vote) state_d = S_IDLE;
        else if (bit_end)    state_d = S_DATA;
      end
      S_DATA:      if (bit_end && bit_cnt == LAST_DATA) state_d = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY:    if (bit_end) state_d = S_STOP;
      S_STOP: begin
        if (at_vote && bit_cnt == LAST_STOP) begin
          decide  = 1'b1;
          state_d = vote ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state       <= S_IDLE;
      sync_q      <= 2'b11;
      sync_vld    <= 2'b00;
      rx_prev     <= 1'b0;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      samp        <= 2'b11;
      data_sh     <= '0;
      par_bit_q   <= 1'b0;
      stop_err_q  <= 1'b0;
      rx_data     <= '0;
      rx_data_vld <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      state    <= state_d;
      sync_q   <= {sync_q[0], rx};
      sync_vld <= {sync_vld[0], 1'b1};
      // Edge history only counts real line samples, so a line held low through
      // reset cannot look like a falling edge once reset drops.
      rx_prev  <= sync_vld[1] & rx_s;

      baud_cnt <= (state == S_IDLE || bit_end) ? '0 : baud_cnt + CW'(1);

      case (state)
        S_DATA:  if (bit_end) bit_cnt <= (bit_cnt == LAST_DATA) ? 4'd0 : bit_cnt + 4'd1;
        S_STOP:  if (bit_end) bit_cnt <= bit_cnt + 4'd1;
        default: bit_cnt <= 4'd0;
      endcase

      if (baud_cnt == CNT_S0) samp[0] <= rx_s;
      if (baud_cnt == CNT_S1) samp[1] <= rx_s;

      if (state == S_START) stop_err_q <= 1'b0;
      if (at_vote) begin
        case (state)
          S_DATA:   data_sh   <= {vote, data_sh[DATA_BITS-1:1]};
          S_PARITY: par_bit_q <= vote;
          S_STOP:   stop_err_q <= stop_bad;
          default:  ;
        endcase
      end

      rx_data_vld <= decide;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      if (decide) begin
        rx_data    <= data_sh;
        parity_err <= HAS_PAR && ((^data_sh ^ ODD_PAR) != par_bit_q);
        frame_err  <= stop_bad;
        break_det  <= (data_sh == '0) && !(HAS_PAR && par_bit_q) && stop_bad;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four instances (8N1, 8E1, 8N2, 7O1) on one
// clock, each with its own line and reset, exercised by per-scenario tasks.
module tb_uart_rx_cfg;

  localparam int BIT = 434;

  logic       clk;
  logic [3:0] rst;
  logic [3:0] rx_line;
  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;

  logic [7:0] n1_data, e1_data, n2_data;
  logic [6:0] o1_data;
  logic n1_vld, n1_perr, n1_ferr, n1_brk, n1_busy;
  logic e1_vld, e1_perr, e1_ferr, e1_brk, e1_busy;
  logic n2_vld, n2_perr, n2_ferr, n2_brk, n2_busy;
  logic o1_vld, o1_perr, o1_ferr, o1_brk, o1_busy;

  uart_rx_cfg #(.CLOCK(50_000_000), .BAUD(115200), .DATA_BITS(8), .PARITY("None"), .STOP_BITS(1)) u_n1 (
    .clk(clk), .rst(rst[0]), .rx(rx_line[0]), .rx_data(n1_data), .rx_data_vld(n1_vld),
    .parity_err(n1_perr), .frame_err(n1_ferr), .break_det(n1_brk), .busy(n1_busy));

  uart_rx_cfg #(.CLOCK(50_000_000), .BAUD(115200), .DATA_BITS(8), .PARITY("Even"), .STOP_BITS(1)) u_e1 (
    .clk(clk), .rst(rst[1]), .rx(rx_line[1]), .rx_data(e1_data), .rx_data_vld(e1_vld),
    .parity_err(e1_perr), .frame_err(e1_ferr), .break_det(e1_brk), .busy(e1_busy));

  uart_rx_cfg #(.CLOCK(50_000_000), .BAUD(115200), .DATA_BITS(8), .PARITY("None"), .STOP_BITS(2)) u_n2 (
    .clk(clk), .rst(rst[2]), .rx(rx_line[2]), .rx_data(n2_data), .rx_data_vld(n2_vld),
    .parity_err(n2_perr), .frame_err(n2_ferr), .break_det(n2_brk), .busy(n2_busy));

  uart_rx_cfg #(.CLOCK(50_000_000), .BAUD(115200), .DATA_BITS(7), .PARITY("Odd"), .STOP_BITS(1)) u_o1 (
    .clk(clk), .rst(rst[3]), .rx(rx_line[3]), .rx_data(o1_data), .rx_data_vld(o1_vld),
    .parity_err(o1_perr), .frame_err(o1_ferr), .break_det(o1_brk), .busy(o1_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts, last word, last flags {parity, frame, break}, pulse cycle.
  int         vld_cnt[4] = '{default: 0};
  logic [8:0] last_data[4];
  logic [2:0] last_flags[4];
  int         last_cyc[4] = '{default: 0};
  logic [6:0] o1_q[$];
  logic       o1_err_seen = 1'b0;

  always @(negedge clk) begin
    if (n1_vld) begin
      vld_cnt[0] <= vld_cnt[0] + 1; last_data[0] <= {1'b0, n1_data};
      last_flags[0] <= {n1_perr, n1_ferr, n1_brk}; last_cyc[0] <= cyc;
    end
    if (e1_vld) begin
      vld_cnt[1] <= vld_cnt[1] + 1; last_data[1] <= {1'b0, e1_data};
      last_flags[1] <= {e1_perr, e1_ferr, e1_brk}; last_cyc[1] <= cyc;
    end
    if (n2_vld) begin
      vld_cnt[2] <= vld_cnt[2] + 1; last_data[2] <= {1'b0, n2_data};
      last_flags[2] <= {n2_perr, n2_ferr, n2_brk}; last_cyc[2] <= cyc;
    end
    if (o1_vld) begin
      vld_cnt[3] <= vld_cnt[3] + 1; last_data[3] <= {2'b00, o1_data};
      last_flags[3] <= {o1_perr, o1_ferr, o1_brk}; last_cyc[3] <= cyc;
      o1_q.push_back(o1_data);
      o1_err_seen <= o1_err_seen | o1_perr | o1_ferr | o1_brk;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive n bits LSB first, one bit time each; optional one-clock inversion at offset glitch_at.
  task automatic send_bits(input int ch, input logic [15:0] bits, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      rx_line[ch] = bits[i];
      for (int k = 1; k <= BIT; k++) begin
        @(negedge clk);
        if (k == glitch_at)          rx_line[ch] = ~bits[i];
        else if (k == glitch_at + 1) rx_line[ch] = bits[i];
      end
    end
  endtask

  task automatic test_reset();
    rst = 4'hF;
    rx_line = 4'hF;
    wait_cycles(5);
    checks++; if (n1_busy !== 1'b0) begin fails++; $display("FAIL reset_n1_busy: got %b expected 0", n1_busy); end
    checks++; if (n1_vld !== 1'b0) begin fails++; $display("FAIL reset_n1_vld: got %b expected 0", n1_vld); end
    checks++; if (n1_data !== 8'h00) begin fails++; $display("FAIL reset_n1_data: got %h expected 00", n1_data); end
    checks++; if (o1_busy !== 1'b0) begin fails++; $display("FAIL reset_o1_busy: got %b expected 0", o1_busy); end
    checks++; if (e1_perr !== 1'b0) begin fails++; $display("FAIL reset_e1_perr: got %b expected 0", e1_perr); end
    checks++; if (n2_ferr !== 1'b0) begin fails++; $display("FAIL reset_n2_ferr: got %b expected 0", n2_ferr); end
    rst = 4'h0;
    wait_cycles(5);
  endtask

  task automatic test_8n1_basic();
    int base, t0, dly;
    base = vld_cnt[0];
    t0 = cyc;
    send_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10, 0);
    wait_cycles(100);
    dly = last_cyc[0] - t0;
    checks++; if (vld_cnt[0] !== base + 1) begin fails++; $display("FAIL basic_count: got %0d expected %0d", vld_cnt[0], base + 1); end
    checks++; if (last_data[0] !== 9'h0A5) begin fails++; $display("FAIL basic_data: got %h expected a5", last_data[0]); end
    checks++; if (last_flags[0] !== 3'b000) begin fails++; $display("FAIL basic_flags: got %b expected 000", last_flags[0]); end
    checks++; if (dly < 4118 || dly > 4138) begin fails++; $display("FAIL basic_latency: got %0d cycles expected about 4123 (9.5 bits)", dly); end
    checks++; if (n1_busy !== 1'b0) begin fails++; $display("FAIL basic_idle: busy got %b expected 0", n1_busy); end
  endtask

  task automatic test_start_glitch();
    int base;
    base = vld_cnt[0];
    rx_line[0] = 1'b0;
    wait_cycles(40);
    checks++; if (n1_busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_start: got %b expected 1", n1_busy); end
    wait_cycles(10);
    rx_line[0] = 1'b1;
    wait_cycles(BIT);
    checks++; if (n1_busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_end: got %b expected 0", n1_busy); end
    checks++; if (vld_cnt[0] !== base) begin fails++; $display("FAIL glitch_no_pulse: got %0d expected %0d", vld_cnt[0], base); end
  endtask

  task automatic test_majority();
    int base;
    base = vld_cnt[0];
    send_bits(0, 16'({1'b1, 8'hC3, 1'b0}), 10, 218);
    wait_cycles(100);
    checks++; if (vld_cnt[0] !== base + 1) begin fails++; $display("FAIL vote_count: got %0d expected %0d", vld_cnt[0], base + 1); end
    checks++; if (last_data[0] !== 9'h0C3) begin fails++; $display("FAIL vote_data: got %h expected c3", last_data[0]); end
    checks++; if (last_flags[0] !== 3'b000) begin fails++; $display("FAIL vote_flags: got %b expected 000", last_flags[0]); end
  endtask

  task automatic test_break();
    int base;
    base = vld_cnt[0];
    rx_line[0] = 1'b0;
    wait_cycles(20 * BIT);
    checks++; if (vld_cnt[0] !== base + 1) begin fails++; $display("FAIL break_count: got %0d expected %0d", vld_cnt[0], base + 1); end
    checks++; if (last_data[0] !== 9'h000) begin fails++; $display("FAIL break_data: got %h expected 00", last_data[0]); end
    checks++; if (last_flags[0] !== 3'b011) begin fails++; $display("FAIL break_flags: got %b expected 011", last_flags[0]); end
    checks++; if (n1_busy !== 1'b1) begin fails++; $display("FAIL break_wait_high: busy got %b expected 1", n1_busy); end
    checks++; if (n1_ferr !== 1'b0) begin fails++; $display("FAIL break_flag_unqualified: got %b expected 0", n1_ferr); end
    rx_line[0] = 1'b1;
    wait_cycles(2 * BIT);
    checks++; if (vld_cnt[0] !== base + 1) begin fails++; $display("FAIL break_single_pulse: got %0d expected %0d", vld_cnt[0], base + 1); end
    checks++; if (n1_busy !== 1'b0) begin fails++; $display("FAIL break_idle: busy got %b expected 0", n1_busy); end
    send_bits(0, 16'({1'b1, 8'h3C, 1'b0}), 10, 0);
    wait_cycles(100);
    checks++; if (last_data[0] !== 9'h03C || vld_cnt[0] !== base + 2) begin
      fails++; $display("FAIL break_recover: got %h/%0d expected 3c/%0d", last_data[0], vld_cnt[0], base + 2);
    end
  endtask

  task automatic test_parity();
    int base;
    base = vld_cnt[1];
    // 0x37 has five ones, so even parity requires a 1.
    send_bits(1, 16'({1'b1, 1'b0, 8'h37, 1'b0}), 11, 0);
    wait_cycles(100);
    checks++; if (last_data[1] !== 9'h037) begin fails++; $display("FAIL par_bad_data: got %h expected 37", last_data[1]); end
    checks++; if (last_flags[1] !== 3'b100) begin fails++; $display("FAIL par_bad_flags: got %b expected 100", last_flags[1]); end
    send_bits(1, 16'({1'b1, 1'b1, 8'h37, 1'b0}), 11, 0);
    wait_cycles(100);
    checks++; if (vld_cnt[1] !== base + 2) begin fails++; $display("FAIL par_count: got %0d expected %0d", vld_cnt[1], base + 2); end
    checks++; if (last_flags[1] !== 3'b000) begin fails++; $display("FAIL par_good_flags: got %b expected 000", last_flags[1]); end
  endtask

  task automatic test_two_stop();
    int base;
    base = vld_cnt[2];
    send_bits(2, 16'({1'b0, 1'b1, 8'h55, 1'b0}), 11, 0);
    wait_cycles(2 * BIT);
    checks++; if (vld_cnt[2] !== base + 1) begin fails++; $display("FAIL stop2_count: got %0d expected %0d", vld_cnt[2], base + 1); end
    checks++; if (last_data[2] !== 9'h055) begin fails++; $display("FAIL stop2_data: got %h expected 55", last_data[2]); end
    checks++; if (last_flags[2] !== 3'b010) begin fails++; $display("FAIL stop2_flags: got %b expected 010", last_flags[2]); end
    checks++; if (n2_busy !== 1'b1) begin fails++; $display("FAIL stop2_wait_high: busy got %b expected 1", n2_busy); end
    rx_line[2] = 1'b1;
    wait_cycles(20);
    checks++; if (n2_busy !== 1'b0) begin fails++; $display("FAIL stop2_idle: busy got %b expected 0", n2_busy); end
    send_bits(2, 16'({1'b1, 1'b1, 8'h0F, 1'b0}), 11, 0);
    wait_cycles(100);
    checks++; if (last_data[2] !== 9'h00F) begin fails++; $display("FAIL stop2_next_data: got %h expected 0f", last_data[2]); end
    checks++; if (last_flags[2] !== 3'b000) begin fails++; $display("FAIL stop2_next_flags: got %b expected 000", last_flags[2]); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [6:0] d;
    logic p;
    o1_q.delete();
    base = vld_cnt[3];
    for (int v = 0; v < 10; v++) begin
      d = 7'(v);
      p = ~^d;
      send_bits(3, 16'({1'b1, p, d, 1'b0}), 10, 0);
    end
    wait_cycles(100);
    checks++; if (vld_cnt[3] !== base + 10) begin fails++; $display("FAIL b2b_count: got %0d expected %0d", vld_cnt[3], base + 10); end
    checks++; if (o1_q.size() !== 10) begin fails++; $display("FAIL b2b_queue: got %0d entries expected 10", o1_q.size()); end
    for (int i = 0; i < 10 && i < o1_q.size(); i++) begin
      checks++; if (o1_q[i] !== 7'(i)) begin fails++; $display("FAIL b2b_value[%0d]: got %h expected %h", i, o1_q[i], 7'(i)); end
    end
    checks++; if (o1_err_seen !== 1'b0) begin fails++; $display("FAIL b2b_errors: got %b expected 0", o1_err_seen); end

    // Eleventh frame aborted by reset with the line held low across it.
    d = 7'h0A;
    p = ~^d;
    send_bits(3, 16'({1'b1, p, d, 1'b0}), 5, 0);
    rx_line[3] = 1'b0;
    rst[3] = 1'b1;
    wait_cycles(3);
    rst[3] = 1'b0;
    wait_cycles(1);
    checks++; if (o1_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", o1_busy); end
    checks++; if (o1_data !== 7'h00) begin fails++; $display("FAIL rst_data: got %h expected 00", o1_data); end
    checks++; if ({o1_vld, o1_perr, o1_ferr, o1_brk} !== 4'b0000) begin
      fails++; $display("FAIL rst_outputs: got %b expected 0000", {o1_vld, o1_perr, o1_ferr, o1_brk});
    end
    wait_cycles(2 * BIT);
    checks++; if (vld_cnt[3] !== base + 10) begin fails++; $display("FAIL rst_no_pulse: got %0d expected %0d", vld_cnt[3], base + 10); end
    checks++; if (o1_busy !== 1'b0) begin fails++; $display("FAIL rst_low_no_start: busy got %b expected 0", o1_busy); end
    rx_line[3] = 1'b1;
    wait_cycles(10);
    send_bits(3, 16'({1'b1, p, d, 1'b0}), 10, 0);
    wait_cycles(100);
    checks++; if (last_data[3] !== 9'h00A || vld_cnt[3] !== base + 11) begin
      fails++; $display("FAIL rst_recover: got %h/%0d expected 0a/%0d", last_data[3], vld_cnt[3], base + 11);
    end
  endtask

  initial begin
    test_reset();
    fork
      begin
        test_8n1_basic();
        test_start_glitch();
        test_majority();
        test_break();
      end
      begin
        test_parity();
        test_two_stop();
      end
      test_back_to_back();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: run not complete after 80000 cycles, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
